// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation codes and widths.
package usr_pkg;

  localparam int USR_MODE_W = 3;

  // Operation select; codes 3'b110 and 3'b111 are reserved and act as HOLD.
  typedef enum logic [USR_MODE_W-1:0] {
    HOLD = 3'b000,
    SHL  = 3'b001,
    SHR  = 3'b010,
    LOAD = 3'b011,
    ROL  = 3'b100,
    ROR  = 3'b101
  } usr_mode_t;

  // True for every mode that moves data one position (and so consumes a bit).
  function automatic logic usr_is_shift(input logic [USR_MODE_W-1:0] mode);
    return (mode == SHL) || (mode == SHR) || (mode == ROL) || (mode == ROR);
  endfunction

endpackage

// File: rtl/usr_bit_cnt.sv
// Shift-remaining counter: loads WIDTH, counts down once per shift and
// saturates at zero. DONE is registered and high exactly when the count is 0.
module usr_bit_cnt #(
  parameter int WIDTH = 8
) (
  input  logic CLK,
  input  logic CLR,
  input  logic EN,
  input  logic load,
  input  logic dec,
  output logic DONE
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic [CW-1:0] remain_q, remain_d;
  logic          done_q, done_d;

  // Next count: load restarts at WIDTH, shifts decrement without wrapping.
  always_comb begin
    remain_d = remain_q;
    if (EN) begin
      if (load) begin
        remain_d = FULL;
      end else if (dec && (remain_q != '0)) begin
        remain_d = remain_q - 1'b1;
      end
    end
    done_d = (remain_d == '0);
  end

  // Count and flag registers; reset means nothing is left to shift.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      remain_q <= '0;
      done_q   <= 1'b1;
    end else begin
      remain_q <= remain_d;
      done_q   <= done_d;
    end
  end

  assign DONE = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register (hold, shift both ways, load, rotate
// both ways) with serial taps at both ends and a shift-remaining DONE flag.
// Optional feature macro: USR_PARITY_EN adds the PAR output (XOR of Q).
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  EN,
  input  logic [USR_MODE_W-1:0] MODE,
  input  logic                  SIN_LSB,
  input  logic                  SIN_MSB,
  input  logic [WIDTH-1:0]      D,
  output logic [WIDTH-1:0]      Q,
  output logic                  SOUT_MSB,
  output logic                  SOUT_LSB,
`ifdef USR_PARITY_EN
  output logic                  PAR,
`endif
  output logic                  DONE
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             load;
  logic             dec;

  // Mode mux: selects the next register contents; reserved codes hold.
  always_comb begin
    q_d = q_q;
    if (EN) begin
      case (MODE)
        SHL:     q_d = {q_q[WIDTH-2:0], SIN_LSB};
        SHR:     q_d = {SIN_MSB, q_q[WIDTH-1:1]};
        LOAD:    q_d = D;
        ROL:     q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        ROR:     q_d = {q_q[0], q_q[WIDTH-1:1]};
        default: q_d = q_q;
      endcase
    end
  end

  // Data register; reset discards any word in flight.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign load = (MODE == LOAD);
  assign dec  = usr_is_shift(MODE);

  usr_bit_cnt #(
    .WIDTH (WIDTH)
  ) u_bit_cnt (
    .CLK  (CLK),
    .CLR  (CLR),
    .EN   (EN),
    .load (load),
    .dec  (dec),
    .DONE (DONE)
  );

  assign Q        = q_q;
  assign SOUT_MSB = q_q[WIDTH-1];
  assign SOUT_LSB = q_q[0];

`ifdef USR_PARITY_EN
  assign PAR = ^q_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8): a vector table of chained
// operations with hand-computed results, plus hand-written reset sequences.
module tb_univ_shift_reg;

  localparam int W = 8;

  logic         clk;
  logic         clr;
  logic         en;
  logic [2:0]   mode;
  logic         sin_lsb;
  logic         sin_msb;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         sout_msb;
  logic         sout_lsb;
  logic         done;
`ifdef USR_PARITY_EN
  logic         par;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  univ_shift_reg #(
    .WIDTH     (W),
    .RESET_VAL (8'h00)
  ) dut (
    .CLK      (clk),
    .CLR      (clr),
    .EN       (en),
    .MODE     (mode),
    .SIN_LSB  (sin_lsb),
    .SIN_MSB  (sin_msb),
    .D        (d),
    .Q        (q),
    .SOUT_MSB (sout_msb),
    .SOUT_LSB (sout_lsb),
`ifdef USR_PARITY_EN
    .PAR      (par),
`endif
    .DONE     (done)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic [2:0]   mode;
    logic         sl;
    logic         sm;
    logic [W-1:0] d;
    logic [W-1:0] exp_q;
    logic         exp_done;
  } vec_t;

  vec_t vecs[$];

  localparam logic [2:0] M_HOLD = 3'b000, M_SHL = 3'b001, M_SHR = 3'b010,
                         M_LOAD = 3'b011, M_ROL = 3'b100, M_ROR = 3'b101;

  function automatic void add(input logic e, input logic [2:0] m, input logic sl,
                              input logic sm, input logic [W-1:0] dd,
                              input logic [W-1:0] eq, input logic ed);
    vec_t v;
    v.en = e; v.mode = m; v.sl = sl; v.sm = sm; v.d = dd;
    v.exp_q = eq; v.exp_done = ed;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic e, input logic [2:0] m, input logic sl,
                       input logic sm, input logic [W-1:0] dd);
    en = e; mode = m; sin_lsb = sl; sin_msb = sm; d = dd;
  endtask

  // One clocked operation, outputs sampled 1 time unit after the edge.
  task automatic step(input logic e, input logic [2:0] m, input logic sl,
                      input logic sm, input logic [W-1:0] dd);
    drive(e, m, sl, sm, dd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    drive(1'b0, M_HOLD, 1'b0, 1'b0, 8'h00);
    clr = 1'b0;
    #12;
    check("reset q", q, 8'h00);
    check("reset done", done, 1'b1);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;

    // Shifts from A5
    add(1, M_LOAD, 0, 0, 8'hA5, 8'hA5, 0);
    add(1, M_SHL,  1, 0, 8'h00, 8'h4B, 0);
    add(1, M_LOAD, 0, 0, 8'hA5, 8'hA5, 0);
    add(1, M_SHR,  1, 0, 8'h00, 8'h52, 0);
    // Single rotations
    add(1, M_LOAD, 0, 0, 8'hA5, 8'hA5, 0);
    add(1, M_ROL,  0, 0, 8'h00, 8'h4B, 0);
    add(1, M_LOAD, 0, 0, 8'hA5, 8'hA5, 0);
    add(1, M_ROR,  0, 0, 8'h00, 8'hD2, 0);
    // Eight ROL restore the word and exhaust the count
    add(1, M_LOAD, 0, 0, 8'hA5, 8'hA5, 0);
    add(1, M_ROL,  1, 1, 8'h00, 8'h4B, 0);
    add(1, M_ROL,  1, 1, 8'h00, 8'h96, 0);
    add(1, M_ROL,  1, 1, 8'h00, 8'h2D, 0);
    add(1, M_ROL,  1, 1, 8'h00, 8'h5A, 0);
    add(1, M_ROL,  1, 1, 8'h00, 8'hB4, 0);
    add(1, M_ROL,  1, 1, 8'h00, 8'h69, 0);
    add(1, M_ROL,  1, 1, 8'h00, 8'hD2, 0);
    add(1, M_ROL,  1, 1, 8'h00, 8'hA5, 1);
    // DONE pacing: 7 shifts keep it low, the 8th raises it, extra shifts saturate
    add(1, M_LOAD, 0, 0, 8'hFF, 8'hFF, 0);
    add(1, M_SHL,  0, 1, 8'h00, 8'hFE, 0);
    add(1, M_SHL,  0, 1, 8'h00, 8'hFC, 0);
    add(1, M_SHL,  0, 1, 8'h00, 8'hF8, 0);
    add(1, M_SHL,  0, 1, 8'h00, 8'hF0, 0);
    add(1, M_SHL,  0, 1, 8'h00, 8'hE0, 0);
    add(1, M_SHL,  0, 1, 8'h00, 8'hC0, 0);
    add(1, M_SHL,  0, 1, 8'h00, 8'h80, 0);
    add(1, M_SHL,  0, 1, 8'h00, 8'h00, 1);
    add(1, M_SHL,  1, 0, 8'h00, 8'h01, 1);
    add(1, M_SHL,  1, 0, 8'h00, 8'h03, 1);
    add(1, M_SHL,  1, 0, 8'h00, 8'h07, 1);
    // Reload at shift 4 restarts the full count of 8
    add(1, M_LOAD, 0, 0, 8'hFF, 8'hFF, 0);
    add(1, M_SHL,  0, 0, 8'h00, 8'hFE, 0);
    add(1, M_SHL,  0, 0, 8'h00, 8'hFC, 0);
    add(1, M_SHL,  0, 0, 8'h00, 8'hF8, 0);
    add(1, M_SHL,  0, 0, 8'h00, 8'hF0, 0);
    add(1, M_LOAD, 0, 0, 8'h0F, 8'h0F, 0);
    add(1, M_SHL,  0, 0, 8'h00, 8'h1E, 0);
    add(1, M_SHL,  0, 0, 8'h00, 8'h3C, 0);
    add(1, M_SHL,  0, 0, 8'h00, 8'h78, 0);
    add(1, M_SHL,  0, 0, 8'h00, 8'hF0, 0);
    add(1, M_SHL,  0, 0, 8'h00, 8'hE0, 0);
    add(1, M_SHL,  0, 0, 8'h00, 8'hC0, 0);
    add(1, M_SHL,  0, 0, 8'h00, 8'h80, 0);
    add(1, M_SHL,  0, 0, 8'h00, 8'h00, 1);
    // Enable low, reserved codes and HOLD change neither data nor count
    add(1, M_LOAD, 0, 0, 8'hA5, 8'hA5, 0);
    add(0, M_LOAD, 0, 0, 8'h11, 8'hA5, 0);
    add(0, M_SHL,  1, 1, 8'h11, 8'hA5, 0);
    add(1, 3'b110, 1, 1, 8'h11, 8'hA5, 0);
    add(1, 3'b111, 1, 1, 8'h11, 8'hA5, 0);
    add(1, M_HOLD, 1, 1, 8'h11, 8'hA5, 0);
    add(1, M_SHR,  0, 1, 8'h00, 8'hD2, 0);
    add(1, M_SHR,  0, 1, 8'h00, 8'hE9, 0);
    add(1, M_SHR,  0, 1, 8'h00, 8'hF4, 0);
    add(1, M_SHR,  0, 1, 8'h00, 8'hFA, 0);
    add(1, M_SHR,  0, 1, 8'h00, 8'hFD, 0);
    add(1, M_SHR,  0, 1, 8'h00, 8'hFE, 0);
    add(1, M_SHR,  0, 1, 8'h00, 8'hFF, 0);
    add(1, M_SHR,  0, 1, 8'h00, 8'hFF, 1);
    // Done already high: EN low must not disturb it
    add(0, M_LOAD, 0, 0, 8'h11, 8'hFF, 1);

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].mode, vecs[i].sl, vecs[i].sm, vecs[i].d);
      check($sformatf("vec%0d q", i), q, vecs[i].exp_q);
      check($sformatf("vec%0d done", i), done, vecs[i].exp_done);
      check($sformatf("vec%0d sout_msb", i), sout_msb, vecs[i].exp_q[W-1]);
      check($sformatf("vec%0d sout_lsb", i), sout_lsb, vecs[i].exp_q[0]);
`ifdef USR_PARITY_EN
      check($sformatf("vec%0d par", i), par, ^vecs[i].exp_q);
`endif
    end

    // Asynchronous reset mid-shift: takes effect without a clock edge
    step(1, M_LOAD, 0, 0, 8'h3C);
    check("pre-reset q", q, 8'h3C);
    check("pre-reset done", done, 1'b0);
    step(1, M_SHL, 0, 0, 8'h00);
    check("pre-reset shift q", q, 8'h78);
    drive(1, M_HOLD, 0, 0, 8'h00);
    #2;
    clr = 1'b0;
    #1;
    check("async reset q", q, 8'h00);
    check("async reset done", done, 1'b1);
    @(negedge clk);
    clr = 1'b1;
    step(1, M_HOLD, 1, 1, 8'hFF);
    check("post-release hold q", q, 8'h00);
    check("post-release hold done", done, 1'b1);
    // First shift after reset: count was cleared, so DONE stays high
    step(1, M_SHL, 1, 0, 8'h00);
    check("post-reset shl q", q, 8'h01);
    check("post-reset shl done", done, 1'b1);

`ifdef USR_PARITY_EN
    step(1, M_LOAD, 0, 0, 8'hA5);
    check("par a5", par, 1'b0);
    step(1, M_LOAD, 0, 0, 8'hA4);
    check("par a4", par, 1'b1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register, the next generation of the 4-bit 74x194-style block in the transmission path.
- Provides hold, shift toward MSB, shift toward LSB, parallel load, and rotate in both directions.
- Separate serial inputs at each end; serial outputs at both ends; full parallel output.
- A shift-remaining counter flags when a loaded word has been fully shifted out, so the framing logic can pace serialisation without its own counter.

Parameters:
WIDTH, 8, register width in bits (>= 2)
RESET_VAL, {WIDTH{1'b0}}, value of Q after reset

Ports:
CLK  input  1  clock, all state updates on rising edge
CLR  input  1  asynchronous active-low reset
EN  input  1  clock enable; 0 = hold everything regardless of MODE
MODE  input  3  operation select (see Behaviour)
SIN_LSB  input  1  serial in, enters bit 0 on shift toward MSB
SIN_MSB  input  1  serial in, enters bit WIDTH-1 on shift toward LSB
D  input  WIDTH  parallel load data
Q  output  WIDTH  register contents
SOUT_MSB  output  1  equals Q[WIDTH-1]
SOUT_LSB  output  1  equals Q[0]
DONE  output  1  1 when shift-remaining count is 0
PAR  output  1  XOR of Q; present only with USR_PARITY_EN

Behaviour:
- Reset
  - CLR=0 asynchronously forces Q=RESET_VAL, REMAIN=0, DONE=1.
  - Reset dominates everything, including mid-shift; the load in progress is discarded.
  - First update is on the first rising CLK edge after CLR returns to 1.
- Clock enable
  - EN=0: Q, REMAIN and DONE hold.
- MODE, sampled at rising CLK when EN=1:
  - 000 HOLD: no change.
  - 001 SHL: Q <= {Q[WIDTH-2:0], SIN_LSB}.
  - 010 SHR: Q <= {SIN_MSB, Q[WIDTH-1:1]}.
  - 011 LOAD: Q <= D.
  - 100 ROL: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - 101 ROR: Q <= {Q[0], Q[WIDTH-1:1]}.
  - 110, 111: treated as HOLD (reserved).
- Counter REMAIN, width $clog2(WIDTH+1), internal:
  - LOAD sets REMAIN=WIDTH.
  - SHL/SHR/ROL/ROR decrement REMAIN, saturating at 0 (no wrap).
  - HOLD leaves REMAIN unchanged.
  - LOAD again while REMAIN>0 restarts the count at WIDTH.
- DONE
  - Registered; DONE=1 exactly when REMAIN==0.
  - Falls in the cycle after a LOAD edge.
  - Rises on the edge of the WIDTH-th shift.
- Timing
  - All outputs are registered or direct slices of Q.
  - Latency is one clock from MODE/data sample to Q.
  - SOUT_MSB/SOUT_LSB are combinational slices of Q; no extra delay.
- Shifting past empty: continues to shift data normally; only REMAIN saturates.

Optional Feature:
- Macro USR_PARITY_EN.
- Defined:
  - Port PAR exists and equals the XOR reduction of Q, computed combinationally from registered Q.
  - Value is RESET_VAL parity during reset.
- Undefined:
  - PAR port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package usr_pkg holds:
  - enum usr_mode_t (HOLD=3'b000, SHL=3'b001, SHR=3'b010, LOAD=3'b011, ROL=3'b100, ROR=3'b101).
  - Localparam USR_MODE_W=3.
- One sub-module usr_bit_cnt:
  - Saturating down-counter with load-to-WIDTH and DONE output.
  - Parameter WIDTH; inputs CLK, CLR, EN, load, dec.
- Top module holds the data register and mode mux.

Test Plan:
1. WIDTH=8: CLR low mid-operation with Q=0x3C -> Q=0x00 and DONE=1 immediately, without waiting for a CLK edge; no change on the first edge after release if MODE=HOLD.
2. LOAD D=0xA5, then SHL with SIN_LSB=1 -> Q=0x4B, SOUT_MSB=0. Separately, LOAD 0xA5 then SHR with SIN_MSB=0 -> Q=0x52, SOUT_LSB=0.
3. Rotations from LOAD 0xA5:
   - ROL -> 0x4B.
   - ROR -> 0xD2.
   - 8 consecutive ROL -> 0xA5 restored.
4. DONE and REMAIN:
   - LOAD 0xFF -> DONE=0 next cycle.
   - 7 SHL -> DONE still 0; 8th SHL -> DONE=1.
   - 3 further SHL -> DONE stays 1, data keeps shifting.
   - LOAD at shift 4 -> DONE=0 and 8 more shifts are needed.
5. Enable, HOLD and reserved codes:
   - EN=0 with MODE=LOAD, D=0x11 -> Q and DONE unchanged.
   - MODE=110 or 111 with EN=1 -> Q unchanged.
6. With USR_PARITY_EN:
   - LOAD 0xA5 -> PAR=0; LOAD 0xA4 -> PAR=1.
   - Build without the macro -> compiles with no PAR port.
